sram_1w1r_bypass: RTL and testbench

Parametrised single-clock 1-write/1-read synthesizable memory. It generalises our fixed 1w1r SRAM macros with the following additions:
- byte write masks
- configurable read latency
- same-cycle write-to-read forwarding
- out-of-range address checks for non-power-of-2 depths
- post-reset zero-initialisation sequencer

It sits between datapath buffers and the memory array, usable as a drop-in behavioural/RTL replacement for macro instances.

---
 rtl/sram_pkg.sv | 33 +++
 rtl/sram_init_seq.sv | 64 ++++++
 rtl/sram_1w1r_bypass.sv | 174 +++++++++++++++++
 tb/tb_sram_1w1r_bypass.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1w1r SRAM with byte masks and bypass.
package sram_pkg;

    localparam int BYTE_W    = 8;
    // Helpers work on a fixed maximum width; callers cast to their own width.
    localparam int MAX_BYTES = 64;
    localparam int MAX_W     = MAX_BYTES * BYTE_W;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_t;

    // Replicate each mask bit across its byte lane.
    function automatic logic [MAX_W-1:0] byte_expand(input logic [MAX_BYTES-1:0] mask);
        logic [MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            res[i*BYTE_W +: BYTE_W] = {BYTE_W{mask[i]}};
        end
        return res;
    endfunction

    // Take masked bytes from new_word and the remaining bytes from old_word.
    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]     old_word,
                                                    input logic [MAX_W-1:0]     new_word,
                                                    input logic [MAX_BYTES-1:0] mask);
        logic [MAX_W-1:0] bm;
        bm = byte_expand(mask);
        return (new_word & bm) | (old_word & ~bm);
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset zero-fill sequencer: walks addresses 0..DEPTH-1 once, then READY.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int DEPTH      = 40,
    parameter int ADDR_WIDTH = 6,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_init_busy,
    output logic                  o_init_we,
    output logic [ADDR_WIDTH-1:0] o_init_addr,
    output init_state_t           o_state
);

    localparam init_state_t           RST_STATE = (INIT_ZERO != 0) ? INIT : READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    init_state_t           r_state;
    init_state_t           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    // State and address counter; reset mid-fill restarts from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: one clear per cycle, leave INIT after clearing the last word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_init_busy = 1'b0;
        o_init_we   = 1'b0;
        case (r_state)
            INIT: begin
                o_init_busy = 1'b1;
                o_init_we   = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = READY;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = RST_STATE;
            end
        endcase
    end

    assign o_init_addr = r_cnt;
    assign o_state     = r_state;

endmodule

// File: rtl/sram_1w1r_bypass.sv
// Single-clock 1-write/1-read memory with byte masks, write-to-read bypass,
// range checking for non-power-of-2 depths, 1- or 2-cycle read latency and
// a post-reset zero-fill.
//
// Handshake: there is no ready signal. While init_busy=0 every wr_en/rd_en
// sampled at a rising edge is accepted; each accepted read yields exactly
// one rd_valid pulse READ_LATENCY cycles later. While init_busy=1 all
// requests are silently dropped (no write, no rd_valid, no error pulse).
module sram_1w1r_bypass
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 240,
    parameter int DEPTH        = 40,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         rd_err,
    output logic                         wr_err,
    output logic                         init_busy
);

    // Parameter sanity, reported at elaboration.
    if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
        $error("sram_1w1r_bypass: DATA_WIDTH must be a multiple of 8");
    end
    if (DATA_WIDTH > MAX_W) begin : g_too_wide
        $error("sram_1w1r_bypass: DATA_WIDTH exceeds helper maximum");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1w1r_bypass: READ_LATENCY must be 1 or 2");
    end
    if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr
        $error("sram_1w1r_bypass: ADDR_WIDTH too small for DEPTH");
    end

    // One extra bit keeps the range compare correct when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    init_state_t           w_init_state;
    logic                  w_init_we;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_init_busy;

    logic                  w_ready;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_user_we;
    logic                  w_rd_acc;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_s1_valid;
    logic                  r_s1_err;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_wr_err;

    sram_init_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_ZERO  (INIT_ZERO)
    ) u_init_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_init_busy (w_init_busy),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr),
        .o_state     (w_init_state)
    );

    assign w_ready       = (w_init_state == READY);
    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_CMP);
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_CMP);
    assign w_user_we     = w_ready & wr_en & w_wr_in_range;
    assign w_rd_acc      = w_ready & rd_en;
    assign w_collide     = w_user_we & rd_en & (wr_addr == rd_addr);

    assign w_old_word = r_mem[wr_addr];
    assign w_merged   = DATA_WIDTH'(byte_merge(MAX_W'(w_old_word), MAX_W'(wr_data),
                                               MAX_BYTES'(wr_mask)));

    // Word returned by a read this cycle: zero out of range, merged word on bypass.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if ((BYPASS != 0) && w_collide) begin
                w_rd_word = w_merged;
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
        end
    end

    // Array write port: zero-fill during INIT, masked user write in READY.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= '0;
        end else if (w_user_we) begin
            r_mem[wr_addr] <= w_merged;
        end
    end

    // First read stage; data holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            r_s1_err   <= w_rd_acc & ~w_rd_in_range;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    // Dropped-write flag, one cycle after the offending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_ready & wr_en & ~w_wr_in_range;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_s2_valid;
        logic                  r_s2_err;
        logic [DATA_WIDTH-1:0] r_s2_data;

        // Extra output register stage for the two-cycle latency option.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_valid <= 1'b0;
                r_s2_err   <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                r_s2_err   <= r_s1_err;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rd_valid = r_s2_valid;
        assign rd_err   = r_s2_err;
        assign rd_data  = r_s2_data;
    end else begin : g_lat1
        assign rd_valid = r_s1_valid;
        assign rd_err   = r_s1_err;
        assign rd_data  = r_s1_data;
    end

    assign wr_err    = r_wr_err;
    assign init_busy = w_init_busy;

endmodule

// File: tb/tb_sram_1w1r_bypass.sv
// Bench for sram_1w1r_bypass: two instances share clock, reset and stimulus
// (A: BYPASS=1, latency 1; B: BYPASS=0, latency 2) against one memory model.
module tb_sram_1w1r_bypass;

    localparam int DW = 240;
    localparam int NB = 30;
    localparam int AW = 6;
    localparam int DEPTH = 40;

    typedef struct packed {
        logic [31:0]   due;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT wiring ----------------
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [NB-1:0] wr_mask;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] a_rd_data, b_rd_data;
    logic          a_rd_valid, a_rd_err, a_wr_err, a_init_busy;
    logic          b_rd_valid, b_rd_err, b_wr_err, b_init_busy;

    sram_1w1r_bypass #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .READ_LATENCY(1), .BYPASS(1), .INIT_ZERO(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_err(a_rd_err),
        .wr_err(a_wr_err), .init_busy(a_init_busy)
    );

    sram_1w1r_bypass #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .READ_LATENCY(2), .BYPASS(0), .INIT_ZERO(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err),
        .wr_err(b_wr_err), .init_busy(b_init_busy)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    logic [DW-1:0] model [DEPTH];
    logic          model_ready = 1'b0;
    exp_t          exp_a_q[$];
    exp_t          exp_b_q[$];

    function automatic logic [DW-1:0] expand(input logic [NB-1:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic logic [NB-1:0] rand_mask();
        logic [NB-1:0] r;
        for (int i = 0; i < NB; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Monitor A: pop one expectation per rd_valid pulse.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_rd_valid) begin
            if (exp_a_q.size() == 0) begin
                chk("a_unexpected_valid", 1, 0);
            end else begin
                e = exp_a_q.pop_front();
                chk("a_due_cycle", cyc, e.due);
                chk("a_rd_err", a_rd_err, e.err);
                chk("a_rd_data", a_rd_data, e.data);
            end
        end
    end

    // Monitor B: same for the latency-2, no-bypass instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_rd_valid) begin
            if (exp_b_q.size() == 0) begin
                chk("b_unexpected_valid", 1, 0);
            end else begin
                e = exp_b_q.pop_front();
                chk("b_due_cycle", cyc, e.due);
                chk("b_rd_err", b_rd_err, e.err);
                chk("b_rd_data", b_rd_data, e.data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one request cycle (called at a negedge, returns at the next one).
    task automatic op(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] wm,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] m, old, merged, da, db;
        logic          wr_ok, rin;
        exp_t          ea, eb;
        wr_en = we; wr_addr = wa; wr_mask = wm; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (model_ready) begin
            wr_ok  = we && (wa < DEPTH);
            rin    = (ra < DEPTH);
            m      = expand(wm);
            old    = wr_ok ? model[wa] : '0;
            merged = (wd & m) | (old & ~m);
            if (re) begin
                db = rin ? model[ra] : '0;
                da = (rin && wr_ok && (wa == ra)) ? merged : db;
                ea.due = cyc + 1; ea.err = !rin; ea.data = da;
                eb.due = cyc + 2; eb.err = !rin; eb.data = db;
                exp_a_q.push_back(ea);
                exp_b_q.push_back(eb);
            end
            if (wr_ok) model[wa] = merged;
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Count cycles with init_busy high, bounded.
    task automatic count_init(output int n);
        n = 0;
        while ((a_init_busy || b_init_busy) && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [AW-1:0] wa, ra;

        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_a_valid", a_rd_valid, 0);
        chk("rst_a_data", a_rd_data, 0);
        chk("rst_a_rd_err", a_rd_err, 0);
        chk("rst_a_wr_err", a_wr_err, 0);
        chk("rst_a_busy", a_init_busy, 1);
        chk("rst_b_valid", b_rd_valid, 0);
        chk("rst_b_data", b_rd_data, 0);
        chk("rst_b_busy", b_init_busy, 1);

        // Zero-fill takes exactly DEPTH cycles
        rst_n = 1'b1;
        count_init(n);
        chk("init_len", n, DEPTH);
        clear_model();
        model_ready = 1'b1;

        // Every word reads back zero, back-to-back
        for (int i = 0; i < DEPTH; i++) op(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(3);

        // Byte mask merge
        op(1'b1, 6'd5, '1, {NB{8'hA5}}, 1'b0, '0);
        op(1'b1, 6'd5, 30'h1, {NB{8'hFF}}, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd5);

        // Same-edge collision, then follow-up read
        op(1'b1, 6'd7, '1, '1, 1'b1, 6'd7);
        op(1'b0, '0, '0, '0, 1'b1, 6'd7);

        // Out-of-range write and read
        op(1'b1, 6'd45, '1, '1, 1'b1, 6'd63);
        chk("a_wr_err_pulse", a_wr_err, 1);
        chk("b_wr_err_pulse", b_wr_err, 1);
        idle(1);
        chk("a_wr_err_clear", a_wr_err, 0);
        chk("b_wr_err_clear", b_wr_err, 0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd13);

        // Back-to-back reads of fresh data
        for (int i = 0; i < 3; i++) op(1'b1, AW'(i), '1, rand_word(), 1'b0, '0);
        for (int i = 0; i < 3; i++) op(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(4);

        // Random traffic with frequent collisions and some out-of-range addresses
        for (int i = 0; i < 150; i++) begin
            wa = AW'($urandom_range(0, 47));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 47));
            op(1'($urandom_range(0, 1)), wa, rand_mask(), rand_word(),
               1'($urandom_range(0, 1)), ra);
        end
        idle(4);
        chk("a_queue_drained", exp_a_q.size(), 0);
        chk("b_queue_drained", exp_b_q.size(), 0);

        // Reset in the middle of zero-fill, requests during INIT are dropped
        op(1'b1, 6'd9, '1, '1, 1'b0, '0);
        idle(3);
        model_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_init_busy) n++;
            @(negedge clk);
        end
        chk("partial_init_busy", n, 20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_a_busy", a_init_busy, 1);
        chk("midreset_a_valid", a_rd_valid, 0);
        rst_n = 1'b1;
        n = 0;
        while ((a_init_busy || b_init_busy) && n < 200) begin
            wr_en = 1'b0; rd_en = 1'b0;
            if (n == 30) begin
                wr_en = 1'b1; wr_addr = 6'd9; wr_mask = '1; wr_data = '1;
                rd_en = 1'b1; rd_addr = 6'd9;
            end
            if (n == 31) begin
                wr_en = 1'b1; wr_addr = 6'd45;
            end
            n++;
            @(negedge clk);
            if (n == 32) begin
                chk("init_a_wr_err", a_wr_err, 0);
                chk("init_b_wr_err", b_wr_err, 0);
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("reinit_len", n, DEPTH);
        clear_model();
        model_ready = 1'b1;
        op(1'b0, '0, '0, '0, 1'b1, 6'd9);
        op(1'b0, '0, '0, '0, 1'b1, 6'd0);
        op(1'b0, '0, '0, '0, 1'b1, 6'd39);
        idle(4);
        chk("a_queue_final", exp_a_q.size(), 0);
        chk("b_queue_final", exp_b_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
